// File: rtl/seq_counter_param.sv
// Loadable up/down counter, range 0..MAX_VAL, wrap or saturate, registered wrap pulse.
// Optional registered Gray-coded output enabled by defining SEQ_COUNTER_GRAY_OUT_EN.
module seq_counter_param #(
  parameter int WIDTH   = 3,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_dn,
  input  logic             sat_mode,
`ifdef SEQ_COUNTER_GRAY_OUT_EN
  output logic [WIDTH-1:0] gray_out,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             wrap_o,
  output logic             at_bound
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] load_val;

  // Out-of-range loads clamp to the bound so values above MAX_VAL stay unreachable.
  assign load_val = (data_in > MAX_V) ? MAX_V : data_in;

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load_en) begin
      count_next = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (count_reg >= MAX_V) begin
          if (!sat_mode) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_reg + ONE;
        end
      end else begin
        if (count_reg == '0) begin
          if (!sat_mode) begin
            count_next = MAX_V;
            wrap_next  = 1'b1;
          end
        end else begin
          count_next = count_reg - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_reg <= RST_V;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign data_out = count_reg;
  assign wrap_o   = wrap_reg;
  assign at_bound = (count_reg == (up_dn ? MAX_V : '0));

`ifdef SEQ_COUNTER_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_reg;

  // Encoded from count_next so the Gray value lands on the same edge as data_out.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      gray_reg <= RST_V ^ (RST_V >> 1);
    end else begin
      gray_reg <= count_next ^ (count_next >> 1);
    end
  end

  assign gray_out = gray_reg;
`endif

endmodule

// File: tb/tb_seq_counter_param.sv
// Directed bench for seq_counter_param with WIDTH=3, MAX_VAL=5, RST_VAL=0.
// Expected values are hand-computed per step.
module tb_seq_counter_param;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic       load_en;
  logic [2:0] data_in;
  logic       up_dn;
  logic       sat_mode;
  logic [2:0] data_out;
  logic       wrap_o;
  logic       at_bound;
`ifdef SEQ_COUNTER_GRAY_OUT_EN
  logic [2:0] gray_out;
`endif

  int total = 0;
  int bad   = 0;

  seq_counter_param #(.WIDTH(3), .MAX_VAL(5), .RST_VAL(0)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .load_en  (load_en),
    .data_in  (data_in),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    .gray_out (gray_out),
`endif
    .data_out (data_out),
    .wrap_o   (wrap_o),
    .at_bound (at_bound)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock, then check count and wrap pulse.
  task automatic step(input string tag, input logic [2:0] exp_cnt, input logic exp_wrap);
    tick();
    chk({tag, "_cnt"}, 8'(data_out), 8'(exp_cnt));
    chk({tag, "_wrap"}, 8'(wrap_o), 8'(exp_wrap));
    $display("step %s: data_out=%0d wrap_o=%0b at_bound=%0b", tag, data_out, wrap_o, at_bound);
  endtask

  initial begin
    clr_n = 1'b0; en = 1'b0; load_en = 1'b0; data_in = 3'd0; up_dn = 1'b1; sat_mode = 1'b0;
    #3;
    chk("rst_cnt", 8'(data_out), 8'd0);
    chk("rst_wrap", 8'(wrap_o), 8'd0);
    chk("rst_at_bound", 8'(at_bound), 8'd0);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    chk("rst_gray", 8'(gray_out), 8'd0);
`endif
    #9 clr_n = 1'b1;

    // Count up with wrap: 0 -> 1,2,3,4,5,0
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    step("up1", 3'd1, 1'b0);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    chk("gray1", 8'(gray_out), 8'b001);
`endif
    step("up2", 3'd2, 1'b0);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    chk("gray2", 8'(gray_out), 8'b011);
`endif
    step("up3", 3'd3, 1'b0);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    chk("gray3", 8'(gray_out), 8'b010);
`endif
    step("up4", 3'd4, 1'b0);
    step("up5", 3'd5, 1'b0);
    chk("up5_at_bound", 8'(at_bound), 8'd1);
    step("up_wrap", 3'd0, 1'b1);
    step("up_after_wrap", 3'd1, 1'b0);

    // Asynchronous reset mid-count at 4, no clock edge needed
    step("pre2", 3'd2, 1'b0);
    step("pre3", 3'd3, 1'b0);
    step("pre4", 3'd4, 1'b0);
    #1 clr_n = 1'b0;
    #1;
    chk("async_rst_cnt", 8'(data_out), 8'd0);
    chk("async_rst_wrap", 8'(wrap_o), 8'd0);
    #1 clr_n = 1'b1;
    step("post_rst", 3'd1, 1'b0);

    // Load 2, then count down saturating: 1,0,0,0
    load_en = 1'b1; data_in = 3'd2;
    step("load2", 3'd2, 1'b0);
    load_en = 1'b0; up_dn = 1'b0; sat_mode = 1'b1;
    step("dn1", 3'd1, 1'b0);
    step("dn0", 3'd0, 1'b0);
    chk("dn0_at_bound", 8'(at_bound), 8'd1);
    step("dn_sat_a", 3'd0, 1'b0);
    step("dn_sat_b", 3'd0, 1'b0);

    // Down wrap: 0 -> 5 with pulse, then 4
    sat_mode = 1'b0;
    step("dn_wrap", 3'd5, 1'b1);
    step("dn_after_wrap", 3'd4, 1'b0);

    // Load clamp, and load beats en
    load_en = 1'b1; en = 1'b1; up_dn = 1'b1; data_in = 3'd7;
    step("load_clamp", 3'd5, 1'b0);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    chk("gray_load5", 8'(gray_out), 8'b111);
`endif
    data_in = 3'd3;
    step("load3", 3'd3, 1'b0);

    // At 5 going up, switch to down at same edge -> 4, then hold
    data_in = 3'd5;
    step("load5", 3'd5, 1'b0);
    load_en = 1'b0; up_dn = 1'b0;
    step("turn_dn", 3'd4, 1'b0);
    en = 1'b0;
    step("hold_a", 3'd4, 1'b0);
    step("hold_b", 3'd4, 1'b0);

    // Saturate up at 5, combinational at_bound follows up_dn
    load_en = 1'b1; data_in = 3'd5;
    step("load5b", 3'd5, 1'b0);
    load_en = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b1;
    step("up_sat", 3'd5, 1'b0);
    chk("up_sat_at_bound", 8'(at_bound), 8'd1);
    up_dn = 1'b0;
    #1;
    chk("at_bound_comb", 8'(at_bound), 8'd0);

    // Wrap pulse then a load clears it
    up_dn = 1'b1; sat_mode = 1'b0;
    step("wrap_again", 3'd0, 1'b1);
    load_en = 1'b1; data_in = 3'd4;
    step("load_clears_wrap", 3'd4, 1'b0);
`ifdef SEQ_COUNTER_GRAY_OUT_EN
    chk("gray_load4", 8'(gray_out), 8'b110);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
